// File: rtl/shift8_seq.sv
// shift8_seq: multi-cycle sequencer for the 8-bit shift datapath.
//
// Accepts one shift command (op, operand, total amount), walks the operand
// through the combinational shifter in passes of at most MAX_STEP places,
// and presents the result on d_out together with a one-cycle done pulse.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   start  in   1      command strobe, sampled only while idle
//   op     in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amt    in   AMT_W  total shift amount
//   d_in   in   8      operand
//   busy   out  1      command in progress (SHIFT or DONE)
//   done   out  1      one-cycle pulse, d_out holds the new result
//   d_out  out  8      result register, held until the next done
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; command latched on the accepting edge
// SHIFT | one pass per edge, rem counts remaining places down to 0
// DONE  | single-cycle result pulse; start ignored, then back to IDLE

module shift8_seq #(
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 3   // bounded by the 2-bit shamt of the shifter bank
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [7:0]       d_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       d_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       work_q, work_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [7:0]       d_out_q, d_out_d;

    logic [1:0]       step;
    logic [AMT_W-1:0] rem_next;
    logic [7:0]       shifted;

    // One pass of the combinational shifter bank.
    function automatic logic [7:0] shift_pass(input logic [1:0] op_i,
                                              input logic [7:0] val,
                                              input logic [1:0] sh);
        logic [15:0] dbl;
        logic [7:0]  res;
        dbl = {val, val} >> sh;
        case (op_i)
            2'b00:   res = val << sh;
            2'b01:   res = val >> sh;
            2'b10:   res = 8'($signed(val) >>> sh);
            default: res = dbl[7:0];   // rotate: low byte of the doubled word
        endcase
        return res;
    endfunction

    // Datapath: step is never 0 in SHIFT because rem is nonzero on entry
    // and the FSM leaves SHIFT on the pass that brings rem to 0.
    always_comb begin
        step = rem_q[1:0];
        if (rem_q >= AMT_W'(MAX_STEP)) begin
            step = 2'(MAX_STEP);
        end
        rem_next = rem_q - AMT_W'(step);
        shifted  = shift_pass(op_q, work_q, step);
    end

    // State and command registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            work_q  <= 8'h00;
            rem_q   <= '0;
            d_out_q <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            d_out_q <= d_out_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        d_out_d = d_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    work_d = d_in;
                    rem_d  = amt;
                    if (amt == '0) begin
                        state_d = S_DONE;
                        d_out_d = d_in;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d = S_DONE;
                    d_out_d = shifted;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs, decoded from registered state only.
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        d_out = d_out_q;
    end

endmodule

// File: tb/tb_shift8_seq.sv
module tb_shift8_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [3:0] amt;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp = 8'h00;

    shift8_seq #(.AMT_W(4), .MAX_STEP(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .amt   (amt),
        .d_in  (d_in),
        .busy  (busy),
        .done  (done),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Reference behaviour over the whole amount, independent of pass splitting.
    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] d, input int a);
        logic [15:0] dbl;
        case (o)
            2'b00:   return (a >= 8) ? 8'h00 : 8'(d << a);
            2'b01:   return (a >= 8) ? 8'h00 : 8'(d >> a);
            2'b10:   return (a >= 8) ? {8{d[7]}} : 8'($signed(d) >>> a);
            default: begin
                dbl = {d, d} >> (a % 8);
                return dbl[7:0];
            end
        endcase
    endfunction

    // Drive one command at a negedge, push its expected result, and return
    // one negedge later with the inputs scrambled.
    task automatic issue(input logic [1:0] o, input logic [7:0] d, input logic [3:0] a);
        start = 1'b1;
        op    = o;
        d_in  = d;
        amt   = a;
        exp_q.push_back(model(o, d, int'(a)));
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        d_in  = ~d;
        amt   = 4'($urandom_range(0, 15));
    endtask

    // Wait (bounded) for done; count cycles after acceptance and busy samples.
    task automatic wait_done(output int cyc, output int busy_n, output bit to);
        cyc = 0;
        busy_n = 0;
        to = 1'b0;
        forever begin
            if (busy) busy_n++;
            if (done) break;
            if (cyc >= 40) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        amt   = 4'd5;
        d_in  = 8'hAA;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (d_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", d_out); end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        begin
            int cyc, bn;
            bit to;
            logic [7:0] e;
            issue(2'b00, 8'h01, 4'd1);
            wait_done(cyc, bn, to);
            e = exp_q.pop_front();
            total++; if (to) begin bad++; $display("FAIL reset_first_timeout got=timeout exp=done"); end
            total++; if (d_out !== e) begin bad++; $display("FAIL reset_first_result got=%h exp=%h", d_out, e); end
            total++; if (cyc != 1) begin bad++; $display("FAIL reset_first_latency got=%0d exp=1", cyc); end
            last_exp = e;
            @(negedge clk);
        end
    endtask

    task automatic test_lsl();
        int cyc, bn;
        bit to;
        logic [7:0] e;
        issue(2'b00, 8'hB5, 4'd7);
        wait_done(cyc, bn, to);
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL lsl_timeout got=timeout exp=done"); end
        total++; if (d_out !== 8'h80) begin bad++; $display("FAIL lsl_result got=%h exp=80", d_out); end
        total++; if (d_out !== e) begin bad++; $display("FAIL lsl_model got=%h exp=%h", d_out, e); end
        total++; if (cyc != 3) begin bad++; $display("FAIL lsl_latency got=%0d exp=3", cyc); end
        total++; if (bn != 4) begin bad++; $display("FAIL lsl_busy_cycles got=%0d exp=4", bn); end
        last_exp = e;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL lsl_after busy=%b done=%b exp=0/0", busy, done); end
        total++; if (d_out !== 8'h80) begin bad++; $display("FAIL lsl_hold got=%h exp=80", d_out); end
    endtask

    task automatic test_asr_ror();
        int cyc, bn;
        bit to;
        logic [7:0] e;
        issue(2'b10, 8'h90, 4'd12);
        wait_done(cyc, bn, to);
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL asr_timeout got=timeout exp=done"); end
        total++; if (d_out !== 8'hFF || e !== 8'hFF) begin bad++; $display("FAIL asr_result got=%h exp=ff", d_out); end
        total++; if (cyc != 4) begin bad++; $display("FAIL asr_latency got=%0d exp=4", cyc); end
        last_exp = e;
        @(negedge clk);
        issue(2'b11, 8'h81, 4'd9);
        wait_done(cyc, bn, to);
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL ror_timeout got=timeout exp=done"); end
        total++; if (d_out !== 8'hC0 || e !== 8'hC0) begin bad++; $display("FAIL ror_result got=%h exp=c0", d_out); end
        total++; if (cyc != 3) begin bad++; $display("FAIL ror_latency got=%0d exp=3", cyc); end
        last_exp = e;
        @(negedge clk);
    endtask

    task automatic test_zero_amt();
        int cyc, bn;
        bit to;
        logic [7:0] e;
        issue(2'b01, 8'h3C, 4'd0);
        wait_done(cyc, bn, to);
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL zero_timeout got=timeout exp=done"); end
        total++; if (d_out !== 8'h3C || e !== 8'h3C) begin bad++; $display("FAIL zero_result got=%h exp=3c", d_out); end
        total++; if (cyc != 0) begin bad++; $display("FAIL zero_latency got=%0d exp=0", cyc); end
        total++; if (bn != 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=1", bn); end
        last_exp = e;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_after_busy got=%b exp=0", busy); end
    endtask

    // start held high: the bench tracks when the sequencer is idle and only
    // those samples turn into commands.
    task automatic test_back_to_back();
        int cnt = 0;
        int accepted = 0;
        int dones = 0;
        int spacing = (4 + 2) / 3 + 2;
        logic [7:0] e;
        for (int i = 0; i < 44; i++) begin
            if (done) begin
                dones++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_unexpected_done got=done exp=none dout=%h", d_out);
                end else begin
                    e = exp_q.pop_front();
                    if (d_out !== e) begin bad++; $display("FAIL b2b_result got=%h exp=%h", d_out, e); end
                    last_exp = e;
                end
            end else begin
                total++;
                if (d_out !== last_exp) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", d_out, last_exp); end
            end
            if (i < 24) begin
                start = 1'b1;
                op    = 2'b11;
                amt   = 4'd4;
                d_in  = 8'($urandom_range(0, 255));
                if (cnt == 0) begin
                    exp_q.push_back(model(op, d_in, int'(amt)));
                    accepted++;
                    cnt = spacing - 1;
                end else begin
                    cnt--;
                end
            end else begin
                start = 1'b0;
                if (exp_q.size() == 0 && !busy) break;
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
        total++; if (dones != accepted) begin bad++; $display("FAIL b2b_done_count got=%0d exp=%0d", dones, accepted); end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int dc0;
        int cyc, bn;
        bit to;
        logic [7:0] e;
        issue(2'b01, 8'hFF, 4'd15);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done got=%b exp=0", done); end
        total++; if (d_out !== 8'h00) begin bad++; $display("FAIL areset_dout got=%h exp=00", d_out); end
        void'(exp_q.pop_front());
        last_exp = 8'h00;
        dc0 = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (done_cnt != dc0) begin bad++; $display("FAIL areset_no_done got=%0d exp=%0d", done_cnt, dc0); end
        total++; if (busy !== 1'b0 || d_out !== 8'h00) begin bad++; $display("FAIL areset_idle busy=%b dout=%h exp=0/00", busy, d_out); end
        issue(2'b10, 8'h80, 4'd2);
        wait_done(cyc, bn, to);
        e = exp_q.pop_front();
        total++; if (to || d_out !== 8'hE0 || e !== 8'hE0) begin bad++; $display("FAIL areset_recover got=%h exp=e0", d_out); end
        last_exp = e;
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc, bn;
        bit to;
        logic [7:0] e;
        logic [1:0] o;
        logic [7:0] d;
        logic [3:0] a;
        for (int i = 0; i < 48; i++) begin
            o = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            a = 4'(i % 16);
            issue(o, d, a);
            wait_done(cyc, bn, to);
            e = exp_q.pop_front();
            total++;
            if (to || d_out !== e) begin
                bad++; $display("FAIL rand_result op=%0d d=%h amt=%0d got=%h exp=%h", o, d, a, d_out, e);
            end
            total++;
            if (cyc != (int'(a) + 2) / 3) begin
                bad++; $display("FAIL rand_latency amt=%0d got=%0d exp=%0d", a, cyc, (int'(a) + 2) / 3);
            end
            last_exp = e;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_asr_ror();
        test_zero_amt();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
